// File: rtl/neuron_mac_engine.sv
// Neuron evaluator: sign-magnitude dot product over LANES multipliers per cycle,
// plus bias, then arithmetic right shift and saturating ReLU behind a start/done handshake.
module neuron_mac_engine #(
  parameter  int N     = 10,
  parameter  int DW    = 8,
  parameter  int LANES = 4,
  parameter  int OUT_W = 8,
  localparam int ACC_W = 2*DW + $clog2(N+1) + 1,
  localparam int SHW   = $clog2(ACC_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*DW-1:0]   inVec,
  input  logic [N*DW-1:0]   wVec,
  input  logic [2*DW-1:0]   bias,
  input  logic [SHW-1:0]    shamt,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  out
);

  localparam int STEPS = (N + LANES - 1) / LANES;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ACT, FIN} state_t;

  state_t                  state;
  logic [N*DW-1:0]         inReg;
  logic [N*DW-1:0]         wReg;
  logic [SHW-1:0]          shReg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] psum;
  logic signed [ACC_W-1:0] chunk;
  logic signed [ACC_W-1:0] biasExt;
  logic signed [ACC_W-1:0] shifted;
  logic                    psumV;
  logic [IDXW-1:0]         idx;
  logic [OUT_W-1:0]        actVal;
  logic [OUT_W-1:0]        actReg;

  function automatic logic signed [2*DW-1:0] sm2tc(input logic [DW-1:0] x);
    logic signed [2*DW-1:0] mag;
    mag = {{(DW+1){1'b0}}, x[DW-2:0]};
    return x[DW-1] ? -mag : mag;
  endfunction

  function automatic logic signed [ACC_W-1:0] chunkSum(
    input logic [IDXW-1:0] step,
    input logic [N*DW-1:0] a,
    input logic [N*DW-1:0] b
  );
    logic signed [ACC_W-1:0] sum;
    logic signed [2*DW-1:0]  p;
    int unsigned             j;
    sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      j = 32'(step) * 32'(LANES) + k;
      // lanes past the last element of a partial chunk contribute nothing
      if (j < N) begin
        p   = sm2tc(a[j*DW +: DW]) * sm2tc(b[j*DW +: DW]);
        sum = sum + {{(ACC_W-2*DW){p[2*DW-1]}}, p};
      end
    end
    return sum;
  endfunction

  assign chunk   = chunkSum(idx, inReg, wReg);
  assign biasExt = {{(ACC_W-2*DW){bias[2*DW-1]}}, bias};
  assign shifted = acc >>> shReg;

  always_comb begin
    actVal = shifted[OUT_W-1:0];
    if (shifted[ACC_W-1])
      actVal = '0;
    else if (|shifted[ACC_W-2:OUT_W])
      actVal = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      acc    <= '0;
      psum   <= '0;
      psumV  <= 1'b0;
      idx    <= '0;
      inReg  <= '0;
      wReg   <= '0;
      shReg  <= '0;
      actReg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            inReg <= inVec;
            wReg  <= wVec;
            shReg <= shamt;
            acc   <= biasExt;
            idx   <= '0;
            psumV <= 1'b0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          psum  <= chunk;
          psumV <= 1'b1;
          if (psumV)
            acc <= acc + psum;
          idx <= idx + IDXW'(1);
          if (idx == IDXW'(STEPS-1))
            state <= DRAIN;
        end
        DRAIN: begin
          acc   <= acc + psum;
          state <= ACT;
        end
        ACT: begin
          actReg <= actVal;
          state  <= FIN;
        end
        // activation is staged one cycle so out and done rise on the same edge
        FIN: begin
          out   <= actReg;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Bench for neuron_mac_engine: four instances (LANES 4,1,3,10) share stimulus and are
// checked every cycle against a lane-agnostic arithmetic model of the neuron.
module tb_neuron_mac_engine;

  localparam int NI = 4;

  function automatic int lanesOf(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 3;
      default: return 10;
    endcase
  endfunction

  function automatic int latOf(input int g);
    return (10 + lanesOf(g) - 1) / lanesOf(g) + 3;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [79:0] inVec = '0;
  logic [79:0] wVec = '0;
  logic [15:0] bias = '0;
  logic [4:0]  shamt = '0;
  logic        busyD [NI];
  logic        doneD [NI];
  logic [7:0]  outD  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    neuron_mac_engine #(.N(10), .DW(8), .LANES(lanesOf(g)), .OUT_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .inVec (inVec),
      .wVec  (wVec),
      .bias  (bias),
      .shamt (shamt),
      .busy  (busyD[g]),
      .done  (doneD[g]),
      .out   (outD[g])
    );
  end

  int nChecks = 0;
  int nFail   = 0;

  // model state per instance
  bit mBusy [NI];
  bit mDone [NI];
  int mRemain [NI];
  int mPend [NI];
  int mOut [NI];
  int mAccepts [NI];
  int dutDones [NI];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int smv(input logic [7:0] x);
    int m;
    m = int'(x[6:0]);
    return x[7] ? -m : m;
  endfunction

  function automatic int refNeuron(input logic [79:0] a, input logic [79:0] w,
                                   input logic [15:0] b, input logic [4:0] sh);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < 10; i++)
      s += longint'(smv(a[i*8 +: 8])) * longint'(smv(w[i*8 +: 8]));
    s = s >>> sh;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  function automatic logic [79:0] fill(input logic [7:0] v);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [79:0] randVec();
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic bit anyBusy();
    bit b;
    b = 1'b0;
    for (int g = 0; g < NI; g++) b |= mBusy[g];
    return b;
  endfunction

  function automatic int dutBusyCount();
    int c;
    c = 0;
    for (int g = 0; g < NI; g++) c += int'(busyD[g]);
    return c;
  endfunction

  task automatic modelAndCheck();
    for (int g = 0; g < NI; g++) begin
      if (!rst) begin
        mBusy[g] = 1'b0;
        mDone[g] = 1'b0;
        mOut[g]  = 0;
      end else begin
        mDone[g] = 1'b0;
        if (mBusy[g]) begin
          mRemain[g]--;
          if (mRemain[g] == 0) begin
            mBusy[g] = 1'b0;
            mDone[g] = 1'b1;
            mOut[g]  = mPend[g];
          end
        end else if (start) begin
          mPend[g]   = refNeuron(inVec, wVec, bias, shamt);
          mRemain[g] = latOf(g);
          mBusy[g]   = 1'b1;
          mAccepts[g]++;
        end
      end
      if (doneD[g]) dutDones[g]++;
      chk($sformatf("busy[L=%0d]", lanesOf(g)), int'(busyD[g]), int'(mBusy[g]));
      chk($sformatf("done[L=%0d]", lanesOf(g)), int'(doneD[g]), int'(mDone[g]));
      chk($sformatf("out[L=%0d]",  lanesOf(g)), int'(outD[g]),  mOut[g]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    modelAndCheck();
  endtask

  task automatic runVec(input logic [79:0] a, input logic [79:0] w, input logic [15:0] b,
                        input logic [4:0] sh, output int res0);
    int lat [NI];
    int k;
    inVec = a; wVec = w; bias = b; shamt = sh; start = 1'b1;
    step();
    start = 1'b0;
    inVec = randVec(); wVec = randVec(); bias = 16'($urandom); shamt = 5'($urandom);
    res0 = -1;
    for (int g = 0; g < NI; g++) lat[g] = -1;
    k = 1;
    while (k <= 40 && anyBusy()) begin
      step();
      for (int g = 0; g < NI; g++)
        if (doneD[g] && lat[g] < 0) begin
          lat[g] = k;
          if (g == 0) res0 = int'(outD[0]);
        end
      k++;
    end
    chk("drained-busy", dutBusyCount(), 0);
    for (int g = 0; g < NI; g++)
      chk($sformatf("latency[L=%0d]", lanesOf(g)), lat[g], latOf(g));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] a, w;
    int res;
    for (int g = 0; g < NI; g++) begin
      mBusy[g] = 0; mDone[g] = 0; mRemain[g] = 0; mPend[g] = 0; mOut[g] = 0;
      mAccepts[g] = 0; dutDones[g] = 0;
    end

    // power-on reset, outputs checked against model reset state each cycle
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // all +3 times +2, bias +4
    chk("model-pin-64", refNeuron(fill(8'h03), fill(8'h02), 16'd4, 5'd0), 64);
    runVec(fill(8'h03), fill(8'h02), 16'd4, 5'd0, res);
    chk("t2-out", res, 64);

    // asynchronous reset in the middle of MAC
    inVec = fill(8'h05); wVec = fill(8'h05); bias = 16'd0; shamt = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("async-busy[L=%0d]", lanesOf(g)), int'(busyD[g]), 0);
      chk($sformatf("async-done[L=%0d]", lanesOf(g)), int'(doneD[g]), 0);
      chk($sformatf("async-out[L=%0d]",  lanesOf(g)), int'(outD[g]), 0);
    end
    repeat (3) step();
    rst = 1'b1;
    repeat (16) step();
    runVec(fill(8'h03), fill(8'h02), 16'd4, 5'd0, res);
    chk("post-reset-out", res, 64);

    // sign handling and negative zero
    a = '0; w = '0;
    a[7:0] = 8'h85; w[7:0] = 8'h03;
    a[15:8] = 8'h80; w[15:8] = 8'h7F;
    chk("model-pin-5", refNeuron(a, w, 16'd20, 5'd0), 5);
    runVec(a, w, 16'd20, 5'd0, res);
    chk("t3-out-5", res, 5);
    chk("model-pin-relu", refNeuron(a, w, 16'd10, 5'd0), 0);
    runVec(a, w, 16'd10, 5'd0, res);
    chk("t3-out-relu", res, 0);

    // shift and saturation, acc = 161290
    chk("model-pin-sh9", refNeuron(fill(8'h7F), fill(8'h7F), 16'd0, 5'd9), 255);
    chk("model-pin-sh11", refNeuron(fill(8'h7F), fill(8'h7F), 16'd0, 5'd11), 78);
    runVec(fill(8'h7F), fill(8'h7F), 16'd0, 5'd9, res);
    chk("t4-sh9", res, 255);
    runVec(fill(8'h7F), fill(8'h7F), 16'd0, 5'd11, res);
    chk("t4-sh11", res, 78);
    runVec(fill(8'h7F), fill(8'h7F), 16'd0, 5'd0, res);
    chk("t4-sh0", res, 255);

    // start held every cycle with changing vectors: back-to-back and start-while-busy
    for (int g = 0; g < NI; g++) begin mAccepts[g] = 0; dutDones[g] = 0; end
    for (int c = 0; c < 20; c++) begin
      inVec = randVec(); wVec = randVec();
      bias = 16'($urandom_range(0, 2000)); shamt = 5'($urandom_range(0, 8));
      start = 1'b1;
      step();
    end
    start = 1'b0;
    for (int c = 0; c < 40 && anyBusy(); c++) step();
    chk("t5-drained", dutBusyCount(), 0);
    for (int g = 0; g < NI; g++)
      chk($sformatf("t5-done-count[L=%0d]", lanesOf(g)), dutDones[g], mAccepts[g]);

    // randomized vectors across all lane counts
    for (int r = 0; r < 30; r++) begin
      runVec(randVec(), randVec(), 16'($urandom), 5'($urandom_range(0, 12)), res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
